spi_slave: RTL and testbench
============================

# spi_slave

SPI responder: the far end of the team's SPI master link, used where the FPGA is addressed by an external SPI controller or by a second FPGA. Serial inputs are resynchronised into the system clock domain. MOSI words are deserialised MSB-first into `rx_data`. Words from a single-entry transmit buffer are returned on MISO. Frame format is SPI mode 0 (CPOL=0, CPHA=0), full-duplex, fixed `DATA_WIDTH`-bit words, with `cs_n` framing.

## Interface
- `DATA_WIDTH`, 16: word length in bits.
- `BIT_CNT_WIDTH`, 4: bit counter width; must satisfy 2^BIT_CNT_WIDTH = DATA_WIDTH.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous assert and active-low. Deassertion is synchronised externally.
- `sck` input 1: serial clock from the master; asynchronous to `clk`.
- `cs_n` input 1: chip select, active-low; asynchronous.
- `mosi` input 1: serial data in; asynchronous.
- `miso` output 1: serial data out.
- `tx_data` input DATA_WIDTH: next word to send.
- `tx_load` input 1: write strobe for `tx_data`.
- `tx_ready` output 1: transmit buffer empty; it accepts a write this cycle.
- `rx_data` output DATA_WIDTH: last complete received word.
- `new_data` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: frame in progress (state SHIFT).
- `tx_underrun` output 1: one-cycle pulse when a word started with the buffer empty.

## Operation
- `sck`, `cs_n` and `mosi` each pass through a 2-flop synchroniser plus a third history flop. Rise and fall strobes are derived from the last two samples.
- The synchroniser reset values are `sck`=0, `cs_n`=1 and `mosi`=0.
- State IDLE:
  - bit counter = 0.
  - On a synchronised `cs_n` falling edge:
    - load `shift_tx` from the buffer, or all-zeros if the buffer is empty; in the empty case pulse `tx_underrun`.
    - mark the buffer empty.
    - go to SHIFT.
- State SHIFT, on an `sck` rise:
  - `shift_rx` = {shift_rx[DATA_WIDTH-2:0], mosi_sync}.
  - bit counter increments and wraps at DATA_WIDTH.
  - If the counter was DATA_WIDTH-1:
    - next cycle, `rx_data` ← the completed word and `new_data` = 1.
    - set a `reload` flag.
- State SHIFT, on an `sck` fall:
  - If `reload` is set: load `shift_tx` from the buffer as in IDLE (with the same underrun rule) and clear `reload`.
  - Otherwise shift `shift_tx` left by one.
  - This supports back-to-back words with `cs_n` held low.
- `miso` = shift_tx[DATA_WIDTH-1] while in SHIFT.
- Any synchronised `cs_n` rise returns to IDLE immediately.
  - The partial word is discarded: no `new_data`, `rx_data` unchanged.
  - The counter and `reload` are cleared.
- Transmit buffer handshake:
  - A write occurs when `tx_load` && `tx_ready`; `tx_ready` drops the next cycle.
  - `tx_load` while `tx_ready`=0 is ignored.
  - The buffer is freed on the same cycle it is loaded into `shift_tx`.
  - If a buffer load and a `tx_load` fall on the same cycle, the buffer is consumed first and the new word is written; `tx_ready` stays 0.
- Reset values:
  - `miso` 0, `tx_ready` 1, `rx_data` 0, `new_data` 0, `busy` 0, `tx_underrun` 0.
  - State IDLE; all shift registers 0.
- Asserting reset mid-frame aborts the frame with no output pulses. After release, the block waits for a fresh `cs_n` fall.

## Timing
- Input synchronisation latency: 2 `clk` cycles; strobes are valid at cycle 3.
- `sck` high and low phases must each be ≥ 3 `clk` periods, so the maximum SCK rate is clk/6. A master driving this block needs `CLK_DIV` ≥ 3.
- `cs_n` fall to first `sck` rise: ≥ 4 `clk` periods, covering synchroniser latency and the `miso` MSB setup.
- `new_data` is asserted exactly one `clk` after the internal rise strobe for the last bit. `rx_data` is stable until the next `new_data`.
- A `miso` change follows the `sck` fall by 3–4 `clk` cycles. The master samples late in the low phase, which meets this when the phase is ≥ 3 `clk` periods.

## Configuration
- `SPI_SLAVE_MISO_HIZ_EN`:
  - Defined: `miso` is driven 1'bz whenever the state is IDLE, which allows a shared MISO bus with multiple slaves.
  - Undefined: `miso` is driven 0 in IDLE.
  - SHIFT behaviour is identical in both builds.

## Structure
- Shared package `spi_pkg`:
  - state encoding IDLE=1'b0, SHIFT=1'b1.
  - synchroniser depth constant `SPI_SYNC_STAGES`=2.
  - mode-0 polarity constants, shared with the master.
- Sub-module `spi_sync_edge`: 1-bit synchroniser with rise/fall strobe outputs and a reset value parameter. It is instantiated three times.

## Test plan
- Basic frame, SCK = clk/8:
  - Stimulus: buffer preloaded with 16'hA5C3; master sends 16'h5555.
  - Required: `rx_data`=16'h5555 with one `new_data` pulse; master receives 16'hA5C3; `tx_ready` is 1 after the frame starts.
- Back-to-back:
  - Stimulus: `cs_n` held low for two words, sending 16'h1234 then 16'hFFFF; tx words 16'h0F0F then 16'hF0F0, with the second loaded during word 1.
  - Required: two `new_data` pulses with the correct words; master receives both tx words; no `tx_underrun`.
- Underrun:
  - Stimulus: buffer empty at the `cs_n` fall.
  - Required: `tx_underrun` pulses once; master receives 16'h0000; `rx_data` is still correct.
- Abort:
  - Stimulus: `cs_n` raised after 7 bits of 16'hBEEF.
  - Required: no `new_data`, `rx_data` unchanged, `busy`=0 within 3 `clk`; the next full frame of 16'h0001 is received correctly.
- Reset mid-frame:
  - Stimulus: `rst_n` low for 2 cycles at bit 9.
  - Required: all outputs at their reset values, `tx_ready`=1; the next frame is received correctly.
- Handshake collision:
  - Stimulus: `tx_load` of 16'h7777 on the same cycle as a word-boundary reload.
  - Required: 16'h7777 is held in the buffer with `tx_ready`=0, and is transmitted as the following word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, synchroniser depth and mode-0 polarity.
package spi_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   localparam int unsigned SPI_SYNC_STAGES = 2;

   // Mode 0: SCK idles low, data sampled on the leading (rising) edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// 1-bit input synchroniser with a history flop producing rise/fall strobes.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic sync,
   output logic rise_c,
   output logic fall_c
);

   localparam int unsigned DEPTH = SPI_SYNC_STAGES + 1;

   logic [DEPTH-1:0] sr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= {DEPTH{RST_VAL}};
      end else begin
         sr_q <= {sr_q[DEPTH-2:0], d};
      end
   end

   assign sync   = sr_q[DEPTH-2];
   assign rise_c = sr_q[DEPTH-2] & ~sr_q[DEPTH-1];
   assign fall_c = ~sr_q[DEPTH-2] & sr_q[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with a single-entry transmit buffer.
// Define SPI_SLAVE_MISO_HIZ_EN to tri-state miso while idle (shared MISO bus).
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned BIT_CNT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sck,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  new_data,
   output logic                  busy,
   output logic                  tx_underrun
);

   localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

   logic sck_s, sck_rise, sck_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic sample_c, shift_c, load_c;
   logic unused_c;

   spi_state_e               state_q, state_d;
   logic [BIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]    shift_rx_q, shift_rx_d;
   logic [DATA_WIDTH-1:0]    shift_tx_q, shift_tx_d;
   logic [DATA_WIDTH-1:0]    buf_q, buf_d;
   logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
   logic                     reload_q, reload_d;
   logic                     tx_ready_q, tx_ready_d;
   logic                     new_data_q, new_data_d;
   logic                     underrun_q, underrun_d;
   logic                     miso_q, miso_d;

   spi_sync_edge #(.RST_VAL(SPI_CPOL)) u_sync_sck (
      .clk(clk), .rst_n(rst_n), .d(sck), .sync(sck_s), .rise_c(sck_rise), .fall_c(sck_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .d(cs_n), .sync(cs_s), .rise_c(cs_rise), .fall_c(cs_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d(mosi), .sync(mosi_s), .rise_c(mosi_rise), .fall_c(mosi_fall)
   );

   assign sample_c = (SPI_CPOL == SPI_CPHA) ? sck_rise : sck_fall;
   assign shift_c  = (SPI_CPOL == SPI_CPHA) ? sck_fall : sck_rise;
   assign unused_c = ^{sck_s, cs_s, mosi_rise, mosi_fall};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_rx_q <= '0;
         shift_tx_q <= '0;
         buf_q      <= '0;
         rx_data_q  <= '0;
         reload_q   <= 1'b0;
         tx_ready_q <= 1'b1;
         new_data_q <= 1'b0;
         underrun_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_rx_q <= shift_rx_d;
         shift_tx_q <= shift_tx_d;
         buf_q      <= buf_d;
         rx_data_q  <= rx_data_d;
         reload_q   <= reload_d;
         tx_ready_q <= tx_ready_d;
         new_data_q <= new_data_d;
         underrun_q <= underrun_d;
         miso_q     <= miso_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_rx_d = shift_rx_q;
      shift_tx_d = shift_tx_q;
      buf_d      = buf_q;
      rx_data_d  = rx_data_q;
      reload_d   = reload_q;
      tx_ready_d = tx_ready_q;
      new_data_d = 1'b0;
      underrun_d = 1'b0;
      load_c     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            reload_d = 1'b0;
            if (cs_fall) begin
               load_c  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d  = IDLE;
               cnt_d    = '0;
               reload_d = 1'b0;
            end else begin
               if (sample_c) begin
                  shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_s};
                  cnt_d      = cnt_q + BIT_CNT_WIDTH'(1);
                  if (cnt_q == LAST_BIT) begin
                     rx_data_d  = {shift_rx_q[DATA_WIDTH-2:0], mosi_s};
                     new_data_d = 1'b1;
                     reload_d   = 1'b1;
                  end
               end
               if (shift_c) begin
                  if (reload_q) begin
                     load_c   = 1'b1;
                     reload_d = 1'b0;
                  end else begin
                     shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Buffer drains into the shifter before a same-cycle write lands.
      if (load_c) begin
         shift_tx_d = tx_ready_q ? '0 : buf_q;
         underrun_d = tx_ready_q;
         tx_ready_d = 1'b1;
      end
      if (tx_load && tx_ready_q) begin
         buf_d      = tx_data;
         tx_ready_d = 1'b0;
      end

      miso_d = (state_d == SHIFT) ? shift_tx_d[DATA_WIDTH-1] : 1'b0;
   end

   assign tx_ready    = tx_ready_q;
   assign rx_data     = rx_data_q;
   assign new_data    = new_data_q;
   assign tx_underrun = underrun_q;
   assign busy        = (state_q == SHIFT);

`ifdef SPI_SLAVE_MISO_HIZ_EN
   assign miso = (state_q == SHIFT) ? miso_q : 1'bz;
`else
   assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master plus a queue model of the tx buffer.
module tb_spi_slave;

   logic        clk, rst_n, sck, cs_n, mosi, miso;
   logic [15:0] tx_data, rx_data;
   logic        tx_load, tx_ready, new_data, busy, tx_underrun;

   int total = 0;
   int bad   = 0;

   // Reference state: pending tx words, received words, pulse counts.
   logic [15:0] buf_q[$];
   logic [15:0] rx_seen[$];
   int          nd_cnt = 0;
   int          ur_cnt = 0;
   int          ur_exp = 0;
   logic [15:0] mw[3];
   logic [15:0] sw[3];
   logic [15:0] ew[3];
   logic        idle_miso;

   spi_slave #(.DATA_WIDTH(16), .BIT_CNT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
      .new_data(new_data), .busy(busy), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && new_data) begin
         nd_cnt++;
         rx_seen.push_back(rx_data);
      end
      if (rst_n && tx_underrun) ur_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Word boundary in the model: the next word is the buffered one, or zero with an underrun.
   task automatic model_word_start(input int k);
      if (buf_q.size() > 0) begin
         ew[k] = buf_q.pop_front();
      end else begin
         ew[k] = 16'h0000;
         ur_exp++;
      end
   endtask

   task automatic load_tx(input logic [15:0] val, input string tag);
      int n = 0;
      while (tx_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ld_ready"}, tx_ready, 1);
      tx_data = val;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      buf_q.push_back(val);
      chk({tag, "_ld_taken"}, tx_ready, 0);
   endtask

   // One bit: 4 clk low phase (miso sampled at its end), 4 clk high phase; optional tx_load
   // timed to land on the cycle the slave acts on this SCK fall.
   task automatic send_bit(input logic b, input bit coll, input logic [15:0] cv, output logic m);
      sck  = 1'b0;
      mosi = b;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (coll && i == 1) begin
            tx_data = cv;
            tx_load = 1'b1;
         end
         if (coll && i == 2) tx_load = 1'b0;
      end
      m   = miso;
      sck = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_frame(input int nw, input int cut_bits, input bit cut_rst,
                            input int mid_bit, input logic [15:0] mid_val,
                            input int coll_w, input logic [15:0] coll_val, input string tag);
      int   nd0 = nd_cnt;
      int   ur0 = ur_cnt;
      int   bi  = 0;
      logic m;
      bit   coll;
      ur_exp = 0;
      rx_seen.delete();
      cs_n = 1'b0;
      model_word_start(0);
      repeat (2) @(negedge clk);
      for (int w = 0; w < nw; w++) begin
         for (int b = 15; b >= 0; b--) begin
            if (bi == cut_bits) begin
               sck  = 1'b0;
               cs_n = 1'b1;
               if (cut_rst) rst_n = 1'b0;
               return;
            end
            coll = (w == coll_w) && (b == 15);
            if (w > 0 && b == 15) model_word_start(w);
            if (coll) buf_q.push_back(coll_val);
            send_bit(mw[w][b], coll, coll_val, m);
            sw[w][b] = m;
            if (coll) chk({tag, "_coll_ready"}, tx_ready, 0);
            bi++;
            if (bi == 1) begin
               chk({tag, "_busy"}, busy, 1);
               chk({tag, "_ready_early"}, tx_ready, (buf_q.size() == 0) ? 1 : 0);
            end
            if (bi == mid_bit) load_tx(mid_val, tag);
         end
      end
      sck  = 1'b0;
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_nd_count"}, nd_cnt - nd0, nw);
      chk({tag, "_ur_count"}, ur_cnt - ur0, ur_exp);
      for (int w = 0; w < nw; w++) begin
         chk($sformatf("%s_rx%0d", tag, w), (w < rx_seen.size()) ? rx_seen[w] : 16'hxxxx, mw[w]);
         chk($sformatf("%s_miso%0d", tag, w), sw[w], ew[w]);
      end
   endtask

   initial begin
      logic [15:0] rx_before;
      int          nd0, nw, mid;
`ifdef SPI_SLAVE_MISO_HIZ_EN
      idle_miso = 1'bz;
`else
      idle_miso = 1'b0;
`endif
      clk = 1'b0; rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_data = '0; tx_load = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_miso", miso, idle_miso);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_new_data", new_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_underrun", tx_underrun, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Basic frame
      load_tx(16'hA5C3, "basic");
      mw[0] = 16'h5555;
      run_frame(1, -1, 0, -1, 0, -1, 0, "basic");
      chk("basic_idle_miso", miso, idle_miso);

      // Back-to-back, second tx word written mid word 1
      load_tx(16'h0F0F, "b2b");
      mw[0] = 16'h1234; mw[1] = 16'hFFFF;
      run_frame(2, -1, 0, 8, 16'hF0F0, -1, 0, "b2b");

      // Underrun: nothing buffered at cs_n fall
      mw[0] = 16'h3C96;
      run_frame(1, -1, 0, -1, 0, -1, 0, "under");

      // Abort after 7 bits
      load_tx(16'h2468, "abort");
      rx_before = rx_data;
      nd0 = nd_cnt;
      mw[0] = 16'hBEEF;
      run_frame(1, 7, 0, -1, 0, -1, 0, "abort");
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      repeat (4) @(negedge clk);
      chk("abort_nd", nd_cnt - nd0, 0);
      chk("abort_rx_hold", rx_data, rx_before);
      load_tx(16'h8001, "post_abort");
      mw[0] = 16'h0001;
      run_frame(1, -1, 0, -1, 0, -1, 0, "post_abort");

      // Reset at bit 9
      load_tx(16'hABCD, "rst");
      nd0 = nd_cnt;
      mw[0] = 16'hC0DE;
      run_frame(1, 9, 1, -1, 0, -1, 0, "rst");
      repeat (2) @(negedge clk);
      chk("rst_mid_miso", miso, idle_miso);
      chk("rst_mid_tx_ready", tx_ready, 1);
      chk("rst_mid_rx_data", rx_data, 0);
      chk("rst_mid_new_data", new_data, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_underrun", tx_underrun, 0);
      rst_n = 1'b1;
      buf_q.delete();
      repeat (4) @(negedge clk);
      chk("rst_mid_nd", nd_cnt - nd0, 0);
      load_tx(16'h1357, "post_rst");
      mw[0] = 16'h9AB1;
      run_frame(1, -1, 0, -1, 0, -1, 0, "post_rst");

      // Collision: tx_load lands on the word-boundary reload of an empty buffer
      load_tx(16'h1111, "coll");
      mw[0] = 16'h4321; mw[1] = 16'h8765; mw[2] = 16'h0FED;
      run_frame(3, -1, 0, -1, 0, 1, 16'h7777, "coll");

      // Random frames
      for (int r = 0; r < 5; r++) begin
         nw  = $urandom_range(1, 2);
         mid = (nw == 2 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 14) : -1;
         for (int w = 0; w < nw; w++) mw[w] = 16'($urandom);
         if (buf_q.size() == 0 && $urandom_range(0, 1) == 1) load_tx(16'($urandom), "rnd");
         run_frame(nw, -1, 0, mid, 16'($urandom), -1, 0, $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
